mips_div_unit: RTL
==================

// Module: mips_div_unit
// PURPOSE
// - Iterative restoring divider for DIV/DIVU in the EX stage; writes HI/LO via the MEM/WB path.
// - Producer side of the hazard unit's div_stop input: holds EX stalled (stallE=01) while computing.
// - Sequential, with operand capture, a 32-step iteration counter and a result hold until EX advances.
// PARAMETERS
// - DATA_W  32  operand/result width; iteration count equals DATA_W
// - CNT_W   6   iteration counter width, >= clog2(DATA_W)+1
// PORTS
// - clk         in   1       clock
// - reset       in   1       asynchronous, active-high reset
// - div_valid   in   1       valid DIV/DIVU in EX (es_valid && is_div)
// - div_signed  in   1       1=DIV, 0=DIVU; sampled at start
// - div_x       in   DATA_W  dividend (forwarded rs); sampled at start
// - div_y       in   DATA_W  divisor (forwarded rt); sampled at start
// - es_go       in   1       EX instruction leaves EX this cycle
// - flush       in   1       exception/eret flush; aborts any operation
// - div_stop    out  1       stall request to hazard unit
// - div_done    out  1       quot/rem valid for the current EX instruction
// - quot        out  DATA_W  quotient (to LO)
// - rem         out  DATA_W  remainder (to HI)
// BEHAVIOUR
// - Clock and reset: one clock; reset is asynchronous and active-high.
// - Reset: state=IDLE, cnt=0; div_stop=0, div_done=0, quot=0, rem=0.
// - States: IDLE, CALC, DONE.
//   - IDLE -> CALC when div_valid & !flush. Latch |x|, |y|, sign_q=signed&(x[31]^y[31]), sign_r=signed&x[31]. Set cnt=0.
//   - CALC: one restoring step per cycle on a 2*DATA_W remainder/quotient register.
//     - Shift left 1, trial-subtract |y| from the upper half.
//     - If no borrow, keep the difference and set the quotient LSB to 1.
//     - cnt++; on the step where cnt==DATA_W-1, go to DONE.
//   - DONE: quot = sign_q ? -q : q; rem = sign_r ? -r : r (registered, held stable).
//     - DONE -> IDLE when es_go.
// - Latency: start edge in cycle 0, steps in cycles 1..32, div_done=1 from cycle 33.
// - div_stop = div_valid & (state!=DONE), combinational; the hazard unit's stallE=01 follows the same cycle.
// - div_done = (state==DONE); level signal, not a pulse, so EX may capture the result in any cycle until es_go.
// - flush: any state -> IDLE at the next edge.
//   - Partial results are discarded; div_done is not asserted for the aborted op.
//   - flush has priority over es_go and over a new start.
// - es_go & div_valid in DONE (back-to-back divides): return to IDLE; the next op starts on the following edge.
//   - div_stop stays high from the first IDLE cycle.
// - div_valid dropping mid-CALC without flush is illegal; an SVA assertion flags it.
// - Divide by zero (no trap), deterministic result:
//   - unsigned: quot=0xFFFFFFFF, rem=x
//   - signed: quot = x<0 ? 0x00000001 : 0xFFFFFFFF, rem=x
// - 0x80000000 / 0xFFFFFFFF signed: quot=0x80000000, rem=0 (wraps, no exception).
// - Reset mid-operation: immediate return to the reset values above.
// CONFIGURATION
// - DIV_FAST_ZERO_EN defined: if the latched |y|==0 or |x|==0, IDLE->CALC is bypassed.
//   - The FSM goes IDLE->DONE directly, div_done in cycle 1.
//   - Results equal the full-iteration values listed above (x==0 gives quot=0, rem=0).
// - DIV_FAST_ZERO_EN undefined: every operation takes 33 cycles; no zero detection logic.
// STRUCTURE
// - Package mips_div_pkg: DATA_W/CNT_W localparams, div_state_e enum {IDLE,CALC,DONE},
//   and the div-by-zero constant DIV_Q_ZERO=32'hFFFFFFFF.
// - Sub-module div_step (combinational): one restoring shift/subtract step.
//   - Inputs: {rem_hi, q_lo}, divisor. Outputs: next {rem_hi, q_lo}.
//   - Instantiated once; the top holds the FSM, counter, sign fixup and result registers.
// TESTING
// - DIVU 100/7: div_valid=1 at cycle 0 -> div_stop=1 for cycles 0..32; div_done at 33; quot=14, rem=2.
// - DIV -7/2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
//   - DIV 7/-2 -> quot=-3, rem=1.
//   - DIV 0x80000000/-1 -> quot=0x80000000, rem=0.
// - Divide by zero: DIVU 5/0 -> quot=0xFFFFFFFF, rem=5; DIV -5/0 -> quot=1, rem=-5.
//   - With DIV_FAST_ZERO_EN: div_done in cycle 1.
// - flush at cycle 10 of CALC -> IDLE at cycle 11; div_done stays 0; next DIVU 9/3 -> quot=3, rem=0 after 33 cycles.
// - Back-to-back: es_go=1 & div_valid=1 in DONE with a new 20/6 -> IDLE, restart, quot=3, rem=2, div_stop continuous.
//   - Also: es_go held 0 for 5 cycles in DONE -> quot/rem stable, div_stop=0.
// - reset asserted mid-CALC (cycle 17), async -> all outputs 0 immediately; first op after release completes normally.

Source files
------------

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the DIV/DIVU iterative divider.
package mips_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  // Quotient produced by a divide by zero (all ones, no trap).
  localparam logic [DATA_W-1:0] DIV_Q_ZERO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring division step: shift {rem_hi, q_lo} left, trial-subtract the divisor.
module div_step
  import mips_div_pkg::*;
(
  input  logic [2*DATA_W-1:0] work_in,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] work_out
);

  logic [DATA_W:0] trial_hi;
  logic [DATA_W:0] diff;

  // Keep the bit shifted out of the remainder so the trial value is never truncated.
  assign trial_hi = work_in[2*DATA_W-1:DATA_W-1];
  assign diff     = trial_hi - {1'b0, divisor};

  always_comb begin
    if (diff[DATA_W]) begin
      work_out = {trial_hi[DATA_W-1:0], work_in[DATA_W-2:0], 1'b0};
    end else begin
      work_out = {diff[DATA_W-1:0], work_in[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_div_unit.sv
// Iterative restoring divider for DIV/DIVU in EX; stalls EX via div_stop until done.
// Optional DIV_FAST_ZERO_EN: a zero dividend or divisor skips the iteration (done in cycle 1).
module mips_div_unit
  import mips_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              div_valid,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_x,
  input  logic [DATA_W-1:0] div_y,
  input  logic              es_go,
  input  logic              flush,
  output logic              div_stop,
  output logic              div_done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  div_state_e          state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2*DATA_W-1:0] work_reg;
  logic [2*DATA_W-1:0] work_next;
  logic [DATA_W-1:0]   divisor_reg;
  logic                sign_q_reg, sign_r_reg;
  logic [DATA_W-1:0]   quot_reg, rem_reg;

  logic [DATA_W-1:0]   abs_x, abs_y;
  logic                sign_q_start, sign_r_start;
  logic                start;
  logic                last_step;

  assign abs_x        = neg_if(div_signed & div_x[DATA_W-1], div_x);
  assign abs_y        = neg_if(div_signed & div_y[DATA_W-1], div_y);
  assign sign_q_start = div_signed & (div_x[DATA_W-1] ^ div_y[DATA_W-1]);
  assign sign_r_start = div_signed & div_x[DATA_W-1];
  assign last_step    = (cnt_reg == CNT_W'(DATA_W - 1));

  div_step u_div_step (
    .work_in  (work_reg),
    .divisor  (divisor_reg),
    .work_out (work_next)
  );

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (div_valid && !flush) begin
          start      = 1'b1;
          state_next = CALC;
`ifdef DIV_FAST_ZERO_EN
          if (abs_x == '0 || abs_y == '0) state_next = DONE;
`endif
        end
      end
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (es_go) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // flush outranks both completion and a new start
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      divisor_reg <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      quot_reg    <= '0;
      rem_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        work_reg    <= {{DATA_W{1'b0}}, abs_x};
        divisor_reg <= abs_y;
        sign_q_reg  <= sign_q_start;
        sign_r_reg  <= sign_r_start;
        cnt_reg     <= '0;
`ifdef DIV_FAST_ZERO_EN
        if (state_next == DONE) begin
          quot_reg <= (abs_y == '0) ? neg_if(sign_q_start, DIV_Q_ZERO) : '0;
          rem_reg  <= neg_if(sign_r_start, abs_x);
        end
`endif
      end else if (state_reg == CALC) begin
        work_reg <= work_next;
        cnt_reg  <= cnt_reg + 1'b1;
        if (state_next == DONE) begin
          quot_reg <= neg_if(sign_q_reg, work_next[DATA_W-1:0]);
          rem_reg  <= neg_if(sign_r_reg, work_next[2*DATA_W-1:DATA_W]);
        end
      end
    end
  end

  assign div_stop = !reset && div_valid && (state_reg != DONE);
  assign div_done = (state_reg == DONE);
  assign quot     = quot_reg;
  assign rem      = rem_reg;

  // EX must hold the divide until it completes unless a flush aborts it.
  a_valid_held: assert property (@(posedge clk) disable iff (reset)
    (state_reg == CALC && !flush) |-> div_valid);

endmodule
